// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler that shares one I2C master between NUM_REQ requesters,
// with NACK retries, a WAIT_DONE timeout and per-requester completion status.
module i2c_txn_scheduler #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [NUM_REQ*64-1:0]  req_data_i,
   input  logic [NUM_REQ*3-1:0]   req_num_bytes_i,
   output logic [NUM_REQ-1:0]     grant_o,
   output logic [NUM_REQ-1:0]     req_done_o,
   output logic [1:0]             req_status_o,
   output logic                   m_start_o,
   output logic [63:0]            m_data_o,
   output logic [2:0]             m_num_bytes_o,
   input  logic                   m_busy_i,
   input  logic                   m_done_i,
   input  logic                   m_ack_error_i
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SUM_W = IDX_W + 1;
   localparam int unsigned TMO_W = 16;
   localparam int unsigned RTY_W = 3;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_NACK = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARB      = 3'd1,
      S_LAUNCH   = 3'd2,
      S_WAIT     = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [NUM_REQ-1:0] grant_q,    grant_d;
   logic [NUM_REQ-1:0] req_done_q, req_done_d;
   logic [1:0]         status_q,   status_d;
   logic               m_start_q,  m_start_d;
   logic [63:0]        m_data_q,   m_data_d;
   logic [2:0]         m_nb_q,     m_nb_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
   logic [RTY_W-1:0]   retry_q,    retry_d;
   logic [TMO_W-1:0]   tmo_q,      tmo_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [SUM_W-1:0]   cand_sum;
   logic [IDX_W-1:0]   cand;
   logic [63:0]        win_data;
   logic [2:0]         win_nb;
   logic               tmo_hit;
   logic               retry_ok;
   logic [IDX_W-1:0]   next_ptr;

   // Round-robin search: first asserted request at or above rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
         if (cand_sum >= SUM_W'(NUM_REQ)) begin
            cand_sum = cand_sum - SUM_W'(NUM_REQ);
         end
         cand = cand_sum[IDX_W-1:0];
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Payload mux for the winning requester.
   always_comb begin
      win_data = '0;
      win_nb   = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (win_idx == IDX_W'(r)) begin
            win_data = req_data_i[r*64 +: 64];
            win_nb   = req_num_bytes_i[r*3 +: 3];
         end
      end
   end

   // Decision terms used while waiting on the master.
   always_comb begin
      tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      retry_ok = (retry_q < RTY_W'(MAX_RETRIES));
      next_ptr = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; m_done takes priority over a coincident timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (|req_i) state_d = S_ARB;
         S_ARB:      state_d = win_found ? S_LAUNCH : S_IDLE;
         S_LAUNCH:   if (!m_busy_i) state_d = S_WAIT;
         S_WAIT: begin
            if (m_done_i) begin
               state_d = (m_ack_error_i && retry_ok) ? S_LAUNCH : S_COMPLETE;
            end else if (tmo_hit) begin
               state_d = S_COMPLETE;
            end
         end
         S_COMPLETE: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values; all of these are registered below.
   always_comb begin
      grant_d    = grant_q;
      req_done_d = '0;
      status_d   = status_q;
      m_start_d  = 1'b0;
      m_data_d   = m_data_q;
      m_nb_d     = m_nb_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      retry_d    = retry_q;
      tmo_d      = tmo_q;
      case (state_q)
         S_ARB: begin
            if (win_found) begin
               grant_d   = NUM_REQ'(1) << win_idx;
               gnt_idx_d = win_idx;
               m_data_d  = win_data;
               m_nb_d    = win_nb;
               retry_d   = '0;
            end else begin
               grant_d = '0;
            end
         end
         S_LAUNCH: begin
            if (!m_busy_i) begin
               m_start_d = 1'b1;
               tmo_d     = '0;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (m_done_i) begin
               if (m_ack_error_i) begin
                  if (retry_ok) begin
                     retry_d = retry_q + RTY_W'(1);
                  end else begin
                     status_d   = ST_NACK;
                     req_done_d = grant_q;
                  end
               end else begin
                  status_d   = ST_OK;
                  req_done_d = grant_q;
               end
            end else if (tmo_hit) begin
               status_d   = ST_TMO;
               req_done_d = grant_q;
            end
         end
         S_COMPLETE: begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
         end
         default: ;
      endcase
   end

   // Registered outputs and bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= '0;
         req_done_q <= '0;
         status_q   <= ST_OK;
         m_start_q  <= 1'b0;
         m_data_q   <= '0;
         m_nb_q     <= '0;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         retry_q    <= '0;
         tmo_q      <= '0;
      end else begin
         grant_q    <= grant_d;
         req_done_q <= req_done_d;
         status_q   <= status_d;
         m_start_q  <= m_start_d;
         m_data_q   <= m_data_d;
         m_nb_q     <= m_nb_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         retry_q    <= retry_d;
         tmo_q      <= tmo_d;
      end
   end

   assign grant_o       = grant_q;
   assign req_done_o    = req_done_q;
   assign req_status_o  = status_q;
   assign m_start_o     = m_start_q;
   assign m_data_o      = m_data_q;
   assign m_num_bytes_o = m_nb_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Scoreboard bench for i2c_txn_scheduler with a behavioural I2C master model.
module tb_i2c_txn_scheduler;

   localparam int NR  = 4;
   localparam int TMO = 50;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*64-1:0]  req_data = '0;
   logic [NR*3-1:0]   req_num_bytes = '0;
   logic [NR-1:0]     grant_o;
   logic [NR-1:0]     req_done_o;
   logic [1:0]        req_status_o;
   logic              m_start_o;
   logic [63:0]       m_data_o;
   logic [2:0]        m_num_bytes_o;
   logic              m_busy = 1'b0;
   logic              m_done = 1'b0;
   logic              m_ack_error = 1'b0;

   i2c_txn_scheduler #(
      .NUM_REQ(NR), .MAX_RETRIES(2), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_i(req), .req_data_i(req_data), .req_num_bytes_i(req_num_bytes),
      .grant_o(grant_o), .req_done_o(req_done_o), .req_status_o(req_status_o),
      .m_start_o(m_start_o), .m_data_o(m_data_o), .m_num_bytes_o(m_num_bytes_o),
      .m_busy_i(m_busy), .m_done_i(m_done), .m_ack_error_i(m_ack_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         idx;
      logic [1:0] st;
      logic [63:0] data;
      logic [2:0] nb;
      int         starts;
      int         lat;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Master model configuration
   int         done_lat = 2;
   logic [7:0] nack_mask = '0;
   bit         stall = 1'b0;
   bit         release_busy = 1'b0;
   bit         active = 1'b0;
   int         cnt = 0;
   int         attempt = 0;

   // Behavioural master: busy from start to done, done after done_lat cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_ack_error = 1'b0;
         active = 1'b0; attempt = 0;
      end else begin
         m_done = 1'b0; m_ack_error = 1'b0;
         if (req_done_o != '0) attempt = 0;
         if (m_start_o) begin
            m_busy = 1'b1; active = 1'b1; cnt = done_lat;
         end else if (active) begin
            if (stall) begin
               if (release_busy) begin
                  m_busy = 1'b0; active = 1'b0; stall = 1'b0; release_busy = 1'b0;
               end
            end else if (cnt <= 1) begin
               m_done = 1'b1; m_ack_error = nack_mask[attempt];
               attempt++; m_busy = 1'b0; active = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Monitor: counts starts, pops the scoreboard on every completion.
   int  mon_starts = 0;
   int  start_cyc = 0;
   bit  prev_start = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         mon_starts = 0; prev_start = 1'b0;
      end else begin
         if (m_start_o) begin
            check("start_not_back_to_back", 64'(prev_start), 64'd0);
            mon_starts++;
            start_cyc = cyc;
         end
         prev_start = m_start_o;
         if (req_done_o != '0) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: req_done=%b expected none", req_done_o);
            end else begin
               e = exp_q.pop_front();
               check("done_onehot", 64'(req_done_o), 64'(4'b0001 << e.idx));
               check("grant",       64'(grant_o),    64'(4'b0001 << e.idx));
               check("status",      64'(req_status_o), 64'(e.st));
               check("m_data",      m_data_o, e.data);
               check("m_num_bytes", 64'(m_num_bytes_o), 64'(e.nb));
               check("start_count", 64'(mon_starts), 64'(e.starts));
               if (e.lat > 0) check("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
            mon_starts = 0;
         end
      end
   end

   // Issue one request mask, wait for a completion, then drop the requests.
   task automatic do_txn(input logic [NR-1:0] mask, input int idx, input logic [63:0] d,
                         input logic [2:0] nb, input logic [1:0] st, input int starts,
                         input int lat, input bit perturb);
      exp_t e;
      bit   seen;
      e.idx = idx; e.st = st; e.data = d; e.nb = nb; e.starts = starts; e.lat = lat;
      exp_q.push_back(e);
      req_data[idx*64 +: 64]   = d;
      req_num_bytes[idx*3 +: 3] = nb;
      req = mask;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (perturb && grant_o != '0) begin
            req_data[idx*64 +: 64]    = ~d;
            req_num_bytes[idx*3 +: 3] = nb + 3'd1;
         end
         if (req_done_o != '0) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL txn_timeout: no req_done for requester %0d within 300 cycles", idx);
      end
      @(negedge clk);
      req = '0;
   endtask

   initial begin
      int   dones;
      int   nstart;
      exp_t e;
      bit   seen;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_grant",    64'(grant_o), 64'd0);
      check("rst_req_done", 64'(req_done_o), 64'd0);
      check("rst_status",   64'(req_status_o), 64'd0);
      check("rst_m_start",  64'(m_start_o), 64'd0);
      check("rst_m_data",   m_data_o, 64'd0);
      check("rst_m_nb",     64'(m_num_bytes_o), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Fairness: all four held, expect 0,1,2,3,0
      for (int r = 0; r < NR; r++) begin
         req_data[r*64 +: 64]    = {8{8'(8'h10 + r)}};
         req_num_bytes[r*3 +: 3] = 3'(r + 1);
      end
      for (int k = 0; k < 5; k++) begin
         e.idx = k % NR; e.st = 2'b00; e.data = {8{8'(8'h10 + (k % NR))}};
         e.nb = 3'((k % NR) + 1); e.starts = 1; e.lat = 0;
         exp_q.push_back(e);
      end
      req = 4'b1111;
      dones = 0;
      for (int c = 0; c < 500 && dones < 5; c++) begin
         @(negedge clk);
         if (req_done_o != '0) dones++;
      end
      check("fair_done_count", 64'(dones), 64'd5);
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);

      // Single transfer from requester 1 (rr_ptr is now 1)
      do_txn(4'b0010, 1, 64'h0000_0000_0000_3CA5, 3'd2, 2'b00, 1, 0, 1'b0);
      // rr_ptr must now be 2: requesters 0..2 all asking, 2 wins
      do_txn(4'b0111, 2, 64'hDEAD_BEEF_0000_1111, 3'd0, 2'b00, 1, 0, 1'b0);

      // NACK on every attempt: three starts, status 01
      nack_mask = 8'hFF;
      do_txn(4'b0001, 0, 64'h0102_0304_0506_0708, 3'd4, 2'b01, 3, 0, 1'b0);
      // NACK first only, payload changed after grant: two starts, status 00
      nack_mask = 8'h01;
      do_txn(4'b0100, 2, 64'hCAFE_F00D_1234_5678, 3'd7, 2'b00, 2, 0, 1'b1);
      nack_mask = 8'h00;

      // Timeout: master stalls with busy held
      stall = 1'b1;
      do_txn(4'b0001, 0, 64'h0000_0000_0000_00AA, 3'd1, 2'b10, 1, TMO, 1'b0);
      // Next request must wait for m_busy to drop
      e.idx = 1; e.st = 2'b00; e.data = 64'h5555_0000_AAAA_1111; e.nb = 3'd3;
      e.starts = 1; e.lat = 0;
      exp_q.push_back(e);
      req_data[1*64 +: 64] = e.data;
      req_num_bytes[1*3 +: 3] = e.nb;
      req = 4'b0010;
      nstart = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_start_o) nstart++;
      end
      check("no_start_while_busy", 64'(nstart), 64'd0);
      check("grant_held_in_launch", 64'(grant_o), 64'(4'b0010));
      release_busy = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (req_done_o != '0) seen = 1'b1;
      end
      check("busy_release_done", 64'(seen), 64'd1);
      @(negedge clk);
      req = '0;

      // m_done and timeout expiry in the same cycle: done wins
      done_lat = 49;
      do_txn(4'b1000, 3, 64'h7777_6666_5555_4444, 3'd5, 2'b00, 1, TMO, 1'b0);
      done_lat = 2;

      // Reset in the middle of WAIT_DONE
      stall = 1'b1;
      req_data[1*64 +: 64] = 64'h9999;
      req = 4'b0010;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (m_start_o) seen = 1'b1;
      end
      repeat (5) @(negedge clk);
      check("pre_reset_grant", 64'(grant_o), 64'(4'b0010));
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant",    64'(grant_o), 64'd0);
      check("mid_rst_m_start",  64'(m_start_o), 64'd0);
      check("mid_rst_req_done", 64'(req_done_o), 64'd0);
      req = '0;
      stall = 1'b0;
      release_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(4'b1000, 3, 64'h0F0E_0D0C_0B0A_0908, 3'd6, 2'b00, 1, 0, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
